// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - shared types and sizing helpers for the register arbiter
package register_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Index width with a floor of one bit so that two requesters still get a real counter.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/register_arbiter_rr_pick.sv
// rtl/register_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick
    import register_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any_req,
    output logic [IW-1:0]      winner
);

    logic          hi_hit;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan lets the lowest index overwrite; the hi set covers indices at/above ptr.
    always_comb begin
        hi_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = IW'(i);
                if (IW'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
        any_req = |req;
        winner  = hi_hit ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/register_arbiter.sv
// rtl/register_arbiter.sv - round-robin owner of the shared capture register
module register_arbiter
    import register_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 1,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] data_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         out,
    output logic                     busy
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = idx_width(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    state_t           state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    next_ptr;
    logic [IW-1:0]    pick_ptr;
    logic [IW-1:0]    winner;
    logic [CW-1:0]    burst_cnt;
    logic             any_req;
    logic             owner_req;
    logic [WIDTH-1:0] owner_data;
    logic             beat;
    logic             rel;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == IW'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IW'(i)) begin
                owner_req  = req[i];
                owner_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // A release re-arbitrates in the same edge, so the picker must already see the advanced ptr.
    always_comb begin
        beat     = (state == GRANT) && owner_req;
        rel      = (state == GRANT) && (!owner_req || (burst_cnt == LAST_CNT));
        next_ptr = (owner == LAST_IDX) ? '0 : owner + 1'b1;
        pick_ptr = rel ? next_ptr : ptr;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            gnt       <= '0;
            ack       <= '0;
            out       <= '0;
        end else begin
            ack <= '0;
            if (beat) begin
                out <= owner_data;
                ack <= onehot(owner);
            end
            if (state == IDLE || rel) begin
                burst_cnt <= '0;
                if (rel) begin
                    ptr <= next_ptr;
                end
                if (any_req) begin
                    state <= GRANT;
                    owner <= winner;
                    gnt   <= onehot(winner);
                end else begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            end else if (beat) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_register_arbiter.sv
// tb/tb_register_arbiter.sv - self-checking bench for register_arbiter
module tb_register_arbiter;

    localparam int N  = 4;
    localparam int MB = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = '0;
    logic [3:0] data_in = '0;
    logic [3:0] gnt, ack;
    logic [0:0] out;
    logic       busy;
    logic [3:0] req1  = '0;
    logic [3:0] data1 = 4'b0010;
    logic [3:0] gnt1, ack1;
    logic [0:0] out1;
    logic       busy1;

    always #5 clk = ~clk;

    register_arbiter #(.NUM_REQ(4), .WIDTH(1), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .gnt(gnt), .ack(ack), .out(out), .busy(busy)
    );

    register_arbiter #(.NUM_REQ(4), .WIDTH(1), .MAX_BURST(1)) dut_mb1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .data_in(data1),
        .gnt(gnt1), .ack(ack1), .out(out1), .busy(busy1)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       out;
        logic       busy;
    } obs_t;

    typedef struct {
        logic [3:0] req;
        logic [3:0] data;
        obs_t       exp;
    } vec_t;

    obs_t exp_q[$];
    int   glog[$];
    int   tests = 0;
    int   fails = 0;
    logic [3:0] prev_gnt = '0;

    bit   m_busy;
    int   m_owner, m_ptr, m_cnt;
    logic m_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_out = 1'b0;
        exp_q.delete();
        prev_gnt = '0;
    endtask

    // Behavioural reference: what the outputs must look like after the coming edge.
    task automatic model_step(input logic [3:0] r, input logic [3:0] d, output obs_t o);
        bit rel = 0;
        bit hit = 0;
        int idx;
        o.ack = '0;
        if (m_busy) begin
            if (r[m_owner[1:0]]) begin
                m_out = d[m_owner[1:0]];
                o.ack[m_owner[1:0]] = 1'b1;
                m_cnt++;
                rel = (m_cnt == MB);
            end else begin
                rel = 1;
            end
            if (rel) m_ptr = (m_owner + 1) % N;
        end
        if (!m_busy || rel) begin
            m_cnt = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!hit && r[idx[1:0]]) begin
                    hit = 1;
                    m_owner = idx;
                end
            end
            m_busy = hit;
        end
        o.gnt  = m_busy ? 4'(1 << m_owner) : 4'd0;
        o.out  = m_out;
        o.busy = m_busy;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] d, input logic [3:0] r1,
                         input string tag, output obs_t a);
        obs_t e;
        @(negedge clk);
        req = r; data_in = d; req1 = r1;
        model_step(r, d, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        a = {gnt, ack, out, busy};
        e = exp_q.pop_front();
        chk(tag, 32'(a), 32'(e));
        chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
        if (gnt != '0 && gnt != prev_gnt) glog.push_back(oh2i(gnt));
        prev_gnt = gnt;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; req1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl[8];
    obs_t a;
    int   cnt, zero_gnt;
    int   ack_cnt[4];
    logic [3:0] eg1, ea1;
    logic       eo1;

    initial begin
        model_reset();
        #1;
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gnt_mb1", 32'(gnt1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // MAX_BURST=1 instance alternates 0,1,0,1 with one ack per grant.
        for (int c = 0; c < 8; c++) begin
            drive(4'b0000, 4'b0000, 4'b0011, "mb1_idle_main", a);
            eg1 = (c % 2 == 0) ? 4'b0001 : 4'b0010;
            ea1 = (c == 0) ? 4'b0000 : ((c % 2 == 1) ? 4'b0001 : 4'b0010);
            eo1 = (c >= 2) && (c % 2 == 0);
            chk("mb1_gnt", 32'(gnt1), 32'(eg1));
            chk("mb1_ack", 32'(ack1), 32'(ea1));
            chk("mb1_out", 32'(out1), 32'(eo1));
            chk("mb1_busy", 32'(busy1), 32'd1);
            chk("mb1_onehot", 32'($countones(gnt1) <= 1), 32'd1);
        end
        drive(4'b0000, 4'b0000, 4'b0000, "mb1_stop", a);

        // Single requester 2: data 1,0,1,1,1 on beats, non-owner data is noise.
        tbl[0] = '{4'b0100, 4'b0100, '{4'b0100, 4'b0000, 1'b0, 1'b1}};
        tbl[1] = '{4'b0100, 4'b0100, '{4'b0100, 4'b0100, 1'b1, 1'b1}};
        tbl[2] = '{4'b0100, 4'b1011, '{4'b0100, 4'b0100, 1'b0, 1'b1}};
        tbl[3] = '{4'b0100, 4'b0111, '{4'b0100, 4'b0100, 1'b1, 1'b1}};
        tbl[4] = '{4'b0100, 4'b0100, '{4'b0100, 4'b0100, 1'b1, 1'b1}};
        tbl[5] = '{4'b0100, 4'b0100, '{4'b0100, 4'b0100, 1'b1, 1'b1}};
        tbl[6] = '{4'b0000, 4'b0000, '{4'b0000, 4'b0000, 1'b1, 1'b0}};
        tbl[7] = '{4'b0000, 4'b0000, '{4'b0000, 4'b0000, 1'b1, 1'b0}};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].req, tbl[i].data, 4'b0000, "single_model", a);
            chk($sformatf("single_tbl[%0d]", i), 32'(a), 32'(tbl[i].exp));
        end

        // Reset mid-burst on requester 0.
        apply_reset();
        drive(4'b0001, 4'b0001, 4'b0000, "midrst_grant", a);
        drive(4'b0001, 4'b0001, 4'b0000, "midrst_beat1", a);
        @(negedge clk);
        req = 4'b0001;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_ack", 32'(ack), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;
        model_reset();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            drive(4'b0001, (c % 2 == 0) ? 4'b0001 : 4'b1110, 4'b0000, "fresh_burst", a);
            if (c < 5 && a.ack[0]) cnt++;
        end
        chk("fresh_burst_acks", 32'(cnt), 32'd4);

        // Contention: all four requesters, bit i of data = i[0].
        apply_reset();
        glog.delete();
        zero_gnt = 0;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        for (int c = 0; c < 18; c++) begin
            drive(4'b1111, 4'b1010, 4'b0000, "contention", a);
            if (a.gnt == '0) zero_gnt++;
            for (int i = 0; i < 4; i++) if (a.ack[i]) ack_cnt[i]++;
        end
        chk("contention_no_gap", 32'(zero_gnt), 32'd0);
        chk("contention_grants", 32'(glog.size()), 32'd5);
        for (int i = 0; i < glog.size() && i < 5; i++)
            chk($sformatf("contention_order[%0d]", i), 32'(glog[i]), 32'(i % 4));
        chk("contention_acks0", 32'(ack_cnt[0]), 32'd5);
        for (int i = 1; i < 4; i++)
            chk($sformatf("contention_acks%0d", i), 32'(ack_cnt[i]), 32'd4);

        // Early drop: requester 1 for two beats.
        drive(4'b0000, 4'b0000, 4'b0000, "drop_idle", a);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            drive(4'b0010, 4'b0010, 4'b0000, "early_drop", a);
            if (a.ack[1]) cnt++;
        end
        drive(4'b0000, 4'b0000, 4'b0000, "early_drop_rel", a);
        chk("early_drop_acks", 32'(cnt), 32'd2);
        chk("early_drop_gnt", 32'(a.gnt), 32'd0);
        chk("early_drop_busy", 32'(a.busy), 32'd0);
        drive(4'b1111, 4'b0000, 4'b0000, "ptr2_pick", a);
        chk("ptr2_winner", 32'(a.gnt), 32'b0100);

        // Release owner 2 so ptr=3, then req=1011 grants 3,0,1.
        drive(4'b0000, 4'b0000, 4'b0000, "ptr3_rel", a);
        glog.delete();
        for (int c = 0; c < 11; c++)
            drive(4'b1011, 4'b1001, 4'b0000, "simul", a);
        chk("simul_grants", 32'(glog.size()), 32'd3);
        if (glog.size() == 3) begin
            chk("simul_first", 32'(glog[0]), 32'd3);
            chk("simul_second", 32'(glog[1]), 32'd0);
            chk("simul_third", 32'(glog[2]), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
